cache_tag_lookup: RTL and testbench

- Parametrised N-way set-associative tag store and lookup unit.
- Splits each request address into tag, set, word and byte fields. Compares the tag against all ways of the set and returns a registered hit/miss, the hit way and a replacement victim.
- Sits between the core load/store path and the cache data array; the data array is indexed by resp_set, resp_word and resp_way.
- Supports line fill and a whole-cache flush (sequential walk, one set per cycle).

---
 rtl/cache_pkg.sv | 38 +++
 rtl/cache_plru_tree.sv | 60 ++++++
 rtl/cache_tag_lookup.sv | 235 +++++++++++++++++++++++
 tb/tb_cache_tag_lookup.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache tag lookup block: floored
// clog2, tag width, the address-field struct and the flush FSM encoding.
package cache_pkg;

  function automatic int clog2_floor(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Tag width counts only real (non-zero-width) lower fields.
  function automatic int tag_width(input int addr_bits, input int sets,
                                   input int words, input int bytes);
    return addr_bits - $clog2(sets) - $clog2(words) - $clog2(bytes);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  class cache_types #(
    parameter int TAG_W  = 25,
    parameter int SET_W  = 3,
    parameter int WORD_W = 2,
    parameter int BYTE_W = 2
  );
    typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [SET_W-1:0]  set;
      logic [WORD_W-1:0] word;
      logic [BYTE_W-1:0] byte_off;
    } cache_addr_t;
  endclass

  typedef enum logic {
    ST_READY = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU replacement state for one set (N-1 bits). A set bit
// steers the victim search toward the upper half of that subtree.
module cache_plru_tree
  import cache_pkg::*;
#(
  parameter  int WAY_COUNT = 2,
  localparam int WAY_BITS  = clog2_floor(WAY_COUNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                access_valid_i,
  input  logic [WAY_BITS-1:0] access_way_i,
  output logic [WAY_BITS-1:0] victim_o
);

  if (WAY_COUNT == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear_i, access_valid_i, access_way_i};
    assign victim_o = '0;
  end else begin : g_tree
    localparam int LEVELS = $clog2(WAY_COUNT);

    // Heap-ordered nodes: children of node n are 2n and 2n+1.
    logic [WAY_COUNT-1:1] tree_q, tree_d;
    int vic_node, upd_node;

    always_comb begin
      vic_node = 1;
      for (int l = 0; l < LEVELS; l++) begin
        vic_node = 2 * vic_node + int'(tree_q[vic_node]);
      end
      victim_o = WAY_BITS'(vic_node - WAY_COUNT);
    end

    always_comb begin
      tree_d   = tree_q;
      upd_node = 1;
      if (access_valid_i) begin
        for (int l = 0; l < LEVELS; l++) begin
          tree_d[upd_node] = ~access_way_i[LEVELS-1-l];
          upd_node = 2 * upd_node + int'(access_way_i[LEVELS-1-l]);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignment; the comb blocks
    // above use blocking assignment for their scratch variables.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tree_q <= '0;
      end else if (clear_i) begin
        tree_q <= '0;
      end else begin
        tree_q <= tree_d;
      end
    end
  end

endmodule

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store with registered lookup, line fill and a
// sequential flush. Define CACHE_TAG_LOOKUP_PLRU_EN for tree pseudo-LRU.
module cache_tag_lookup
  import cache_pkg::*;
#(
  parameter  int WORD_CAPACITY   = 64,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int WAY_COUNT       = 2,
  parameter  int ADDR_BITS       = 32,
  parameter  int WORD_BITS       = 32,
  localparam int BLOCK_COUNT     = WORD_CAPACITY / WORDS_PER_BLOCK,
  localparam int SET_COUNT       = BLOCK_COUNT / WAY_COUNT,
  localparam int BYTES_PER_WORD  = WORD_BITS / 8,
  localparam int SET_BITS        = clog2_floor(SET_COUNT),
  localparam int WORD_IDX_BITS   = clog2_floor(WORDS_PER_BLOCK),
  localparam int BYTE_BITS       = clog2_floor(BYTES_PER_WORD),
  localparam int TAG_BITS        = tag_width(ADDR_BITS, SET_COUNT, WORDS_PER_BLOCK, BYTES_PER_WORD),
  localparam int WAY_BITS        = clog2_floor(WAY_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_BITS-1:0]     req_addr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [WAY_BITS-1:0]      resp_way,
  output logic [TAG_BITS-1:0]      resp_tag,
  output logic [SET_BITS-1:0]      resp_set,
  output logic [WORD_IDX_BITS-1:0] resp_word,
  output logic [BYTE_BITS-1:0]     resp_byte,
  output logic                     resp_victim_valid,
  output logic [TAG_BITS-1:0]      resp_victim_tag,
  input  logic                     fill_valid,
  input  logic [ADDR_BITS-1:0]     fill_addr,
  input  logic [WAY_BITS-1:0]      fill_way,
  input  logic                     flush_req,
  output logic                     flush_done
);

  if (!is_pow2(WORD_CAPACITY) || !is_pow2(WORDS_PER_BLOCK) || !is_pow2(WAY_COUNT) ||
      !is_pow2(BYTES_PER_WORD) || (WORD_BITS % 8 != 0) || (WAY_COUNT > BLOCK_COUNT)) begin : g_bad_params
    $error("cache_tag_lookup: counts must be powers of two and WAY_COUNT <= BLOCK_COUNT");
  end

  typedef cache_types #(
    .TAG_W (TAG_BITS),
    .SET_W (SET_BITS),
    .WORD_W(WORD_IDX_BITS),
    .BYTE_W(BYTE_BITS)
  )::cache_addr_t cache_addr_t;

  // Unfloored field widths place each field; a zero-width field masks to 0.
  localparam int WORD_RAW = $clog2(WORDS_PER_BLOCK);
  localparam int BYTE_RAW = $clog2(BYTES_PER_WORD);
  localparam int SET_RAW  = $clog2(SET_COUNT);
  localparam int WORD_LO  = BYTE_RAW;
  localparam int SET_LO   = BYTE_RAW + WORD_RAW;
  localparam int TAG_LO   = SET_LO + SET_RAW;
  localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] SET_MASK  = (ONE << SET_RAW) - ONE;
  localparam logic [ADDR_BITS-1:0] WORD_MASK = (ONE << WORD_RAW) - ONE;
  localparam logic [ADDR_BITS-1:0] BYTE_MASK = (ONE << BYTE_RAW) - ONE;

  function automatic cache_addr_t split_addr(input logic [ADDR_BITS-1:0] a);
    cache_addr_t f;
    f.tag      = TAG_BITS'(a >> TAG_LO);
    f.set      = SET_BITS'((a >> SET_LO) & SET_MASK);
    f.word     = WORD_IDX_BITS'((a >> WORD_LO) & WORD_MASK);
    f.byte_off = BYTE_BITS'(a & BYTE_MASK);
    return f;
  endfunction

  flush_state_e        state_q, state_d;
  logic [SET_BITS-1:0] flush_cnt_q, flush_cnt_d;

  logic [WAY_COUNT-1:0] valid_q [SET_COUNT];
  logic [TAG_BITS-1:0]  tag_q   [SET_COUNT][WAY_COUNT];
  logic [WAY_BITS-1:0]  repl_way_set [SET_COUNT];

  cache_addr_t          req_f, fill_f;
  logic                 req_fire, fill_en, hit;
  logic [WAY_COUNT-1:0] match;
  logic [WAY_BITS-1:0]  hit_way, victim_way, fill_way_eff;

  logic                     resp_valid_q, resp_hit_q, resp_victim_valid_q;
  logic [WAY_BITS-1:0]      resp_way_q;
  logic [TAG_BITS-1:0]      resp_tag_q, resp_victim_tag_q;
  logic [SET_BITS-1:0]      resp_set_q;
  logic [WORD_IDX_BITS-1:0] resp_word_q;
  logic [BYTE_BITS-1:0]     resp_byte_q;

  assign req_f        = split_addr(req_addr);
  assign fill_f       = split_addr(fill_addr);
  assign req_fire     = req_valid && req_ready;
  assign fill_en      = fill_valid && (state_q == ST_READY);
  assign fill_way_eff = (WAY_COUNT == 1) ? '0 : fill_way;

  logic unused_fill_bits;
  assign unused_fill_bits = ^{fill_f.word, fill_f.byte_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    req_ready   = 1'b0;
    flush_done  = 1'b0;
    case (state_q)
      ST_READY: begin
        req_ready = 1'b1;
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + SET_BITS'(1);
        if (flush_cnt_q == SET_BITS'(SET_COUNT - 1)) begin
          flush_done  = 1'b1;
          state_d     = ST_READY;
          flush_cnt_d = '0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Lookup sees the arrays as they were before the accepting edge.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      match[w] = valid_q[req_f.set][w] && (tag_q[req_f.set][w] == req_f.tag);
      if (match[w]) hit_way = WAY_BITS'(w);
    end
    hit = |match;
    victim_way = repl_way_set[req_f.set];
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (!valid_q[req_f.set][w]) victim_way = WAY_BITS'(w);
    end
  end

  // NOTE: the tag store is a flop array, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAY_COUNT; w++) tag_q[s][w] <= '0;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
    end else if (fill_en) begin
      valid_q[fill_f.set][fill_way_eff] <= 1'b1;
      tag_q[fill_f.set][fill_way_eff]   <= fill_f.tag;
    end
  end

`ifdef CACHE_TAG_LOOKUP_PLRU_EN
  for (genvar s = 0; s < SET_COUNT; s++) begin : g_plru
    logic fill_here, hit_here;
    assign fill_here = fill_en && (fill_f.set == SET_BITS'(s));
    assign hit_here  = req_fire && hit && (req_f.set == SET_BITS'(s));

    cache_plru_tree #(.WAY_COUNT(WAY_COUNT)) u_plru (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       ((state_q == ST_FLUSH) && (flush_cnt_q == SET_BITS'(s))),
      .access_valid_i(fill_here || hit_here),
      .access_way_i  (fill_here ? fill_way_eff : hit_way),
      .victim_o      (repl_way_set[s])
    );
  end
`else
  logic [WAY_BITS-1:0] rr_q [SET_COUNT];
  assign repl_way_set = rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_COUNT; s++) rr_q[s] <= '0;
    end else if (state_q == ST_FLUSH) begin
      rr_q[flush_cnt_q] <= '0;
    end else if (fill_en && (WAY_COUNT > 1)) begin
      rr_q[fill_f.set] <= rr_q[fill_f.set] + WAY_BITS'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q        <= 1'b0;
      resp_hit_q          <= 1'b0;
      resp_way_q          <= '0;
      resp_tag_q          <= '0;
      resp_set_q          <= '0;
      resp_word_q         <= '0;
      resp_byte_q         <= '0;
      resp_victim_valid_q <= 1'b0;
      resp_victim_tag_q   <= '0;
    end else begin
      resp_valid_q <= req_fire;
      if (req_fire) begin
        resp_hit_q          <= hit;
        resp_way_q          <= hit ? hit_way : victim_way;
        resp_tag_q          <= req_f.tag;
        resp_set_q          <= req_f.set;
        resp_word_q         <= req_f.word;
        resp_byte_q         <= req_f.byte_off;
        resp_victim_valid_q <= valid_q[req_f.set][victim_way];
        resp_victim_tag_q   <= tag_q[req_f.set][victim_way];
      end
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_hit          = resp_hit_q;
  assign resp_way          = resp_way_q;
  assign resp_tag          = resp_tag_q;
  assign resp_set          = resp_set_q;
  assign resp_word         = resp_word_q;
  assign resp_byte         = resp_byte_q;
  assign resp_victim_valid = resp_victim_valid_q;
  assign resp_victim_tag   = resp_victim_tag_q;

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) req_fire |-> $onehot0(match));

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Self-checking bench for cache_tag_lookup at default parameters: directed
// table, hand-written flush/reset sequences and randomized model comparison.
module tb_cache_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_hit, resp_victim_valid;
  logic [0:0]  resp_way;
  logic [24:0] resp_tag, resp_victim_tag;
  logic [2:0]  resp_set;
  logic [1:0]  resp_word, resp_byte;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic [0:0]  fill_way;
  logic        flush_req, flush_done;

  always #5 clk = ~clk;

  cache_tag_lookup dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_way         (resp_way),
    .resp_tag         (resp_tag),
    .resp_set         (resp_set),
    .resp_word        (resp_word),
    .resp_byte        (resp_byte),
    .resp_victim_valid(resp_victim_valid),
    .resp_victim_tag  (resp_victim_tag),
    .fill_valid       (fill_valid),
    .fill_addr        (fill_addr),
    .fill_way         (fill_way),
    .flush_req        (flush_req),
    .flush_done       (flush_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: 8 sets x 2 ways, fields by plain division.
  bit          v_m [8][2];
  logic [24:0] t_m [8][2];
  int          repl_m [8];
  int          flush_left;

  function automatic logic [24:0] f_tag(input logic [31:0] a);
    return 25'(a / 128);
  endfunction
  function automatic int f_set(input logic [31:0] a);
    return int'((a / 16) % 8);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      repl_m[s] = 0;
      for (int w = 0; w < 2; w++) begin
        v_m[s][w] = 1'b0;
        t_m[s][w] = '0;
      end
    end
    flush_left = 0;
  endtask

  task automatic model_lookup(input logic [31:0] a, output bit hit, output int way,
                              output bit vv, output logic [24:0] vtag);
    int s;
    s = f_set(a);
    hit = 1'b0;
    way = -1;
    for (int w = 0; w < 2; w++)
      if (v_m[s][w] && t_m[s][w] == f_tag(a)) begin
        hit = 1'b1;
        way = w;
      end
    if (!hit) begin
      for (int w = 1; w >= 0; w--) if (!v_m[s][w]) way = w;
      if (way < 0) way = repl_m[s];
    end
    vv   = v_m[s][way];
    vtag = t_m[s][way];
  endtask

  // Replacement policy as an abstract rule: PLRU for 2 ways is true LRU.
  task automatic model_touch(input int s, input int w, input bit is_fill);
`ifdef CACHE_TAG_LOOKUP_PLRU_EN
    repl_m[s] = 1 - w;
`else
    if (is_fill) repl_m[s] = (repl_m[s] + 1) % 2;
`endif
  endtask

  task automatic tick(input bit rv, input logic [31:0] ra, input bit fv, input logic [31:0] fa,
                      input int fw, input bit fl, input bit chk);
    bit acc, e_hit, e_vv;
    int e_way, s;
    logic [24:0] e_vtag;
    if (chk) begin
      check("req_ready", req_ready, flush_left == 0);
      check("flush_done", flush_done, flush_left == 1);
    end
    acc = rv && (flush_left == 0);
    model_lookup(ra, e_hit, e_way, e_vv, e_vtag);
    req_valid = rv; req_addr = ra;
    fill_valid = fv; fill_addr = fa; fill_way = 1'(fw);
    flush_req = fl;
    @(posedge clk);
    #1;
    req_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
    if (chk) begin
      check("resp_valid", resp_valid, acc);
      if (acc) begin
        check("resp_hit", resp_hit, e_hit);
        check("resp_way", resp_way, e_way);
        check("resp_tag", resp_tag, f_tag(ra));
        check("resp_set", resp_set, f_set(ra));
        check("resp_word", resp_word, (ra / 4) % 4);
        check("resp_byte", resp_byte, ra % 4);
        if (!e_hit) begin
          check("victim_valid", resp_victim_valid, e_vv);
          check("victim_tag", resp_victim_tag, e_vtag);
        end
      end
    end
    if (flush_left > 0) begin
      s = 8 - flush_left;
      v_m[s][0] = 1'b0; v_m[s][1] = 1'b0; repl_m[s] = 0;
      flush_left--;
    end else begin
      if (acc && e_hit) model_touch(f_set(ra), e_way, 1'b0);
      if (fv) begin
        s = f_set(fa);
        v_m[s][fw] = 1'b1;
        t_m[s][fw] = f_tag(fa);
        model_touch(s, fw, 1'b1);
      end
      if (fl) flush_left = 8;
    end
  endtask

  typedef struct {
    bit          is_fill;
    logic [31:0] addr;
    int          way;
    bit          e_hit;
    int          e_way;
    bit          e_vv;
    logic [24:0] e_vtag;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fw, s;
    logic [31:0] ra, fa;

    vecs[0] = '{1'b1, 32'h1234, 0, 1'b0, 0, 1'b0, 25'h0};
    vecs[1] = '{1'b0, 32'h1234, 0, 1'b1, 0, 1'b0, 25'h0};
    vecs[2] = '{1'b0, 32'h2234, 0, 1'b0, 1, 1'b0, 25'h0};
    vecs[3] = '{1'b1, 32'h2234, 1, 1'b0, 0, 1'b0, 25'h0};
    vecs[4] = '{1'b0, 32'h3234, 0, 1'b0, 0, 1'b1, 25'h24};
    vecs[5] = '{1'b0, 32'h1234, 0, 1'b1, 0, 1'b0, 25'h0};
`ifdef CACHE_TAG_LOOKUP_PLRU_EN
    vecs[6] = '{1'b0, 32'h3234, 0, 1'b0, 1, 1'b1, 25'h44};
`else
    vecs[6] = '{1'b0, 32'h3234, 0, 1'b0, 0, 1'b1, 25'h24};
`endif

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    fill_valid = 1'b0; fill_addr = '0; fill_way = '0; flush_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_flush_done", flush_done, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_tag", resp_tag, 0);
    rst_n = 1'b1;

    tick(1'b1, 32'h1234, 1'b0, '0, 0, 1'b0, 1'b1);
    check("first_hit", resp_hit, 0);
    check("first_tag", resp_tag, 25'h24);
    check("first_set", resp_set, 3);
    check("first_word", resp_word, 1);
    check("first_byte", resp_byte, 0);
    check("first_way", resp_way, 0);
    check("first_vv", resp_victim_valid, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_fill) begin
        tick(1'b0, '0, 1'b1, vecs[i].addr, vecs[i].way, 1'b0, 1'b1);
      end else begin
        tick(1'b1, vecs[i].addr, 1'b0, '0, 0, 1'b0, 1'b1);
        check($sformatf("vec%0d_hit", i), resp_hit, vecs[i].e_hit);
        check($sformatf("vec%0d_way", i), resp_way, vecs[i].e_way);
        if (!vecs[i].e_hit) begin
          check($sformatf("vec%0d_vv", i), resp_victim_valid, vecs[i].e_vv);
          check($sformatf("vec%0d_vtag", i), resp_victim_tag, vecs[i].e_vtag);
        end
      end
    end

    tick(1'b1, 32'h5234, 1'b1, 32'h5234, 0, 1'b0, 1'b1);
    check("same_edge_miss", resp_hit, 0);
    tick(1'b1, 32'h5234, 1'b0, '0, 0, 1'b0, 1'b1);
    check("repeat_hit", resp_hit, 1);
    check("repeat_way", resp_way, 0);

    tick(1'b0, '0, 1'b0, '0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("flush_ready_low", req_ready, 0);
      check("flush_done_pulse", flush_done, i == 7);
      tick(1'b1, 32'h1234, 1'b1, 32'h1234, 0, 1'b0, 1'b1);
    end
    check("post_flush_ready", req_ready, 1);
    check("post_flush_done", flush_done, 0);
    tick(1'b1, 32'h1234, 1'b0, '0, 0, 1'b0, 1'b1);
    check("post_flush_miss", resp_hit, 0);
    check("post_flush_vv", resp_victim_valid, 0);

    tick(1'b0, '0, 1'b1, 32'h0000_0070, 1, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 0, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 1);
    check("midrst_done", flush_done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b0, '0, 0, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_0070, 1'b0, '0, 0, 1'b0, 1'b1);
    check("midrst_miss", resp_hit, 0);
    check("midrst_vv", resp_victim_valid, 0);
    check("midrst_way", resp_way, 0);

    for (int i = 0; i < 400; i++) begin
      ra = (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 127));
      fa = (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 127));
      fw = int'($urandom_range(0, 1));
      s  = f_set(fa);
      for (int w = 0; w < 2; w++) if (v_m[s][w] && t_m[s][w] == f_tag(fa)) fw = w;
      tick($urandom_range(0, 99) < 70, ra, $urandom_range(0, 99) < 30, fa, fw,
           $urandom_range(0, 99) < 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
